load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit for a RISC-V style core. A byte/halfword store is a
// read-modify-write on a word-wide memory; loads are sign- or zero-extended.
module load_store_unit #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LD   = 3'd1;
  localparam logic [2:0] S_RMW  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [31:0] ADDR_LIM = 32'(MEM_WORDS * 4);

  logic [2:0]  r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;

  logic        w_legal;
  logic        w_misal;
  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_wdata;

  // Unsigned variants only exist for loads.
  always_comb begin
    w_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !req_we;
      default:                w_legal = 1'b0;
    endcase
  end

  assign w_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_err   = !w_legal || w_misal || (req_addr >= ADDR_LIM);

  assign w_byte = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_load = mem_rdata;
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_wdata = r_merge;
    case (r_funct3[1:0])
      2'b00:   w_wdata[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      2'b01:   w_wdata[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default: w_wdata = r_wdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_we     <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_merge  <= 32'd0;
      r_rdata  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_we     <= req_we;
          r_funct3 <= req_funct3;
          r_addr   <= req_addr;
          r_wdata  <= req_wdata;
          r_rdata  <= 32'd0;
          if (w_err)                      r_state <= S_ERR;
          else if (!req_we)               r_state <= S_LD;
          else if (req_funct3 == 3'b010)  r_state <= S_WR;
          else                            r_state <= S_RMW;
        end
        S_LD: begin
          r_rdata <= w_load;
          r_state <= S_DONE;
        end
        S_RMW: begin
          r_merge <= mem_rdata;
          r_state <= S_WR;
        end
        S_WR:           r_state <= S_DONE;
        S_DONE, S_ERR:  if (resp_ready) r_state <= S_IDLE;
        default:        r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes come from state only; the async state reset kills MemWrite at once.
  assign MemRead    = (r_state == S_LD) || (r_state == S_RMW);
  assign MemWrite   = (r_state == S_WR);
  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_wdata  = MemWrite ? w_wdata : 32'd0;
  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_DONE) || (r_state == S_ERR);
  assign resp_err   = (r_state == S_ERR);
  assign resp_rdata = (r_state == S_DONE) ? r_rdata : 32'd0;

endmodule
